// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: a loader (writes) and a fetch
// unit (reads) take turns in bursts of up to MAX_BURST beats, alternating on contention.
module mem_arbiter #(
    parameter int ADDR_LEN  = 11,
    parameter int DATA_LEN  = 40,
    parameter int MAX_BURST = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ld_req_i,
    input  logic [ADDR_LEN-1:0] ld_addr_i,
    input  logic [DATA_LEN-1:0] ld_wdata_i,
    output logic                ld_gnt_o,
    input  logic                fe_req_i,
    input  logic [ADDR_LEN-1:0] fe_addr_i,
    output logic                fe_gnt_o,
    output logic [DATA_LEN-1:0] fe_rdata_o,
    output logic                fe_rvalid_o,
    output logic                mem_rd_o,
    output logic                mem_wr_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    input  logic [DATA_LEN-1:0] mem_rdata_i,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        LD_OWN,
        FE_OWN
    } state_e;

    state_e           state_q, state_d;
    state_e           otherOwn;
    logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
    logic             lastOwnerFe_q, lastOwnerFe_d;
    logic             rvalid_q;
    logic             ldBeat, feBeat, ownerReq, otherReq;

    assign ldBeat   = (state_q == LD_OWN) && ld_req_i;
    assign feBeat   = (state_q == FE_OWN) && fe_req_i;
    assign ownerReq = (state_q == LD_OWN) ? ld_req_i : fe_req_i;
    assign otherReq = (state_q == LD_OWN) ? fe_req_i : ld_req_i;
    assign otherOwn = (state_q == LD_OWN) ? FE_OWN : LD_OWN;

    assign ld_gnt_o    = ldBeat;
    assign fe_gnt_o    = feBeat;
    assign mem_wr_o    = ldBeat;
    assign mem_rd_o    = feBeat;
    assign mem_addr_o  = ldBeat ? ld_addr_i : (feBeat ? fe_addr_i : '0);
    assign mem_wdata_o = (ldBeat || feBeat) ? ld_wdata_i : '0;
    assign busy_o      = (state_q != IDLE);
    assign fe_rvalid_o = rvalid_q;
    assign fe_rdata_o  = rvalid_q ? mem_rdata_i : '0;

    // Burst ends when the owner goes quiet, or when its quota is used up and the other side waits.
    always_comb begin
        state_d       = state_q;
        beatCnt_d     = beatCnt_q;
        lastOwnerFe_d = lastOwnerFe_q;
        unique case (state_q)
            IDLE: begin
                beatCnt_d = '0;
                if (ld_req_i && (!fe_req_i || lastOwnerFe_q)) begin
                    state_d = LD_OWN;
                end else if (fe_req_i) begin
                    state_d = FE_OWN;
                end
            end
            LD_OWN, FE_OWN: begin
                if (ownerReq && (beatCnt_q != CNT_MAX)) begin
                    beatCnt_d = beatCnt_q + CNT_W'(1);
                end
                if (!ownerReq || (otherReq && (beatCnt_q >= CNT_LAST))) begin
                    lastOwnerFe_d = (state_q == FE_OWN);
                    state_d       = otherReq ? otherOwn : IDLE;
                    beatCnt_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            beatCnt_q     <= '0;
            lastOwnerFe_q <= 1'b1;
            rvalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            beatCnt_q     <= beatCnt_d;
            lastOwnerFe_q <= lastOwnerFe_d;
            rvalid_q      <= mem_rd_o;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random requester traffic, all checked
// against an owner/burst-length reference model and a shadow copy of memory contents.
module tb_mem_arbiter;

    localparam int AL = 11;
    localparam int DL = 40;
    localparam int MB = 8;
    localparam int OWN_NONE = 0;
    localparam int OWN_LD   = 1;
    localparam int OWN_FE   = 2;

    logic          clk = 1'b0;
    logic          rstN;
    logic          ldReq, feReq;
    logic [AL-1:0] ldAddr, feAddr;
    logic [DL-1:0] ldWdata;
    logic          ldGnt, feGnt, feRvalid, memRd, memWr, busy;
    logic [DL-1:0] feRdata, memWdata, memRdata;
    logic [AL-1:0] memAddr;

    logic [DL-1:0] memArr [0:(1<<AL)-1] = '{default: '0};
    logic [DL-1:0] memRef [0:(1<<AL)-1] = '{default: '0};
    logic [DL-1:0] rdataReg = '0;

    int            checks = 0;
    int            failures = 0;
    int            mOwner, mBeats;
    bit            mLastFe, mPend;
    logic [DL-1:0] mPendData;
    bit            eLd, eFe;
    bit            oLdGnt, oFeGnt, oMemWr, oRvalid, oBusy;
    logic [AL-1:0] oAddr;
    logic [DL-1:0] oRdata;

    mem_arbiter #(.ADDR_LEN(AL), .DATA_LEN(DL), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .ld_req_i(ldReq), .ld_addr_i(ldAddr), .ld_wdata_i(ldWdata), .ld_gnt_o(ldGnt),
        .fe_req_i(feReq), .fe_addr_i(feAddr), .fe_gnt_o(feGnt),
        .fe_rdata_o(feRdata), .fe_rvalid_o(feRvalid),
        .mem_rd_o(memRd), .mem_wr_o(memWr), .mem_addr_o(memAddr),
        .mem_wdata_o(memWdata), .mem_rdata_i(memRdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory seen by the arbiter.
    always @(posedge clk) begin
        if (memWr) memArr[memAddr] <= memWdata;
        if (memRd) rdataReg <= memArr[memAddr];
    end
    assign memRdata = rdataReg;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit lr, input logic [AL-1:0] la, input logic [DL-1:0] lw,
                                 input bit fr, input logic [AL-1:0] fa);
        ldReq = lr; ldAddr = la; ldWdata = lw; feReq = fr; feAddr = fa;
    endtask

    task automatic checkOutput();
        logic [AL-1:0] expAddr;
        expAddr = eLd ? ldAddr : (eFe ? feAddr : '0);
        checkVal("ld_gnt", 64'(ldGnt), 64'(eLd));
        checkVal("fe_gnt", 64'(feGnt), 64'(eFe));
        checkVal("mem_wr", 64'(memWr), 64'(eLd));
        checkVal("mem_rd", 64'(memRd), 64'(eFe));
        checkVal("mem_addr", 64'(memAddr), 64'(expAddr));
        if (!eFe) checkVal("mem_wdata", 64'(memWdata), 64'(eLd ? ldWdata : '0));
        checkVal("busy", 64'(busy), 64'(mOwner != OWN_NONE));
        checkVal("fe_rvalid", 64'(feRvalid), 64'(mPend));
        checkVal("fe_rdata", 64'(feRdata), 64'(mPend ? mPendData : '0));
    endtask

    // One clock of the reference: who owns the memory, how long the current tenure has run.
    task automatic runCycle();
        int            nOwner, nBeats;
        bit            nLastFe, mine, other;
        logic [DL-1:0] rdExp;
        @(negedge clk);
        eLd = (mOwner == OWN_LD) && ldReq;
        eFe = (mOwner == OWN_FE) && feReq;
        oLdGnt = ldGnt; oFeGnt = feGnt; oMemWr = memWr; oRvalid = feRvalid;
        oBusy = busy; oAddr = memAddr; oRdata = feRdata;
        checkOutput();
        nOwner = mOwner; nBeats = mBeats; nLastFe = mLastFe;
        if (mOwner == OWN_NONE) begin
            nBeats = 0;
            if (ldReq && (!feReq || mLastFe)) nOwner = OWN_LD;
            else if (feReq) nOwner = OWN_FE;
        end else begin
            mine  = (mOwner == OWN_LD) ? ldReq : feReq;
            other = (mOwner == OWN_LD) ? feReq : ldReq;
            if (mine) nBeats = mBeats + 1;
            if (!mine || (other && nBeats >= MB)) begin
                nLastFe = (mOwner == OWN_FE);
                nOwner  = other ? (3 - mOwner) : OWN_NONE;
                nBeats  = 0;
            end
        end
        rdExp = memRef[feAddr];
        @(posedge clk);
        if (eLd) memRef[ldAddr] = ldWdata;
        mPend = eFe; mPendData = rdExp;
        mOwner = nOwner; mBeats = nBeats; mLastFe = nLastFe;
        #1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        mOwner = OWN_NONE; mBeats = 0; mLastFe = 1'b1; mPend = 1'b0; mPendData = '0;
        #1;
        checkVal("rst_busy", 64'(busy), 64'd0);
        checkVal("rst_gnt", 64'({ldGnt, feGnt}), 64'd0);
        checkVal("rst_strobes", 64'({memRd, memWr}), 64'd0);
        checkVal("rst_rvalid", 64'(feRvalid), 64'd0);
        @(posedge clk);
        #1;
        checkVal("rst_hold_busy", 64'(busy), 64'd0);
        checkVal("rst_hold_gnt", 64'({ldGnt, feGnt, memRd, memWr}), 64'd0);
        rstN = 1'b1;
    endtask

    task automatic failTimeout(input string tag);
        checks++;
        failures++;
        $error("[TB] FAIL %s observed=timeout expected=grant", tag);
    endtask

    initial begin
        int            n, match, code, expCode, pLd, pFe;
        bit            granted;
        logic [63:0]   rnd;
        logic [AL-1:0] ra;
        logic [DL-1:0] rw;
        bit            lastLdGnt, lastFeGnt;

        rstN = 1'b0;
        applyStimulus(0, '0, '0, 0, '0);
        @(posedge clk);
        #1;
        doReset();

        // Single write to address 5.
        applyStimulus(1, AL'(5), 40'h12_3456_789A, 0, '0);
        granted = 0;
        for (int i = 0; i < 10 && !granted; i++) begin
            runCycle();
            granted = oLdGnt;
        end
        if (!granted) failTimeout("wr_grant");
        checkVal("wr_addr", 64'(oAddr), 64'd5);
        checkVal("wr_strobe", 64'(oMemWr), 64'd1);
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        checkVal("wr_single_beat", 64'(oLdGnt), 64'd0);
        runCycle();
        checkVal("wr_then_idle", 64'(oBusy), 64'd0);

        // Read it back.
        applyStimulus(0, '0, '0, 1, AL'(5));
        granted = 0;
        for (int i = 0; i < 10 && !granted; i++) begin
            runCycle();
            granted = oFeGnt;
        end
        if (!granted) failTimeout("rd_grant");
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        checkVal("rd_rvalid", 64'(oRvalid), 64'd1);
        checkVal("rd_rdata", 64'(oRdata), 64'h12_3456_789A);
        runCycle();

        // Simultaneous requests from IDLE alternate winners, loader first after reset.
        doReset();
        applyStimulus(1, AL'(9), 40'hAA_0000_0001, 1, AL'(9));
        runCycle();
        runCycle();
        checkVal("arb_first_ld", 64'({oLdGnt, oFeGnt}), 64'b10);
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        runCycle();
        applyStimulus(1, AL'(9), 40'hAA_0000_0002, 1, AL'(9));
        runCycle();
        runCycle();
        checkVal("arb_second_fe", 64'({oLdGnt, oFeGnt}), 64'b01);
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        runCycle();

        // Both held continuously: 8 loader, 8 fetch, 8 loader beats, back to back.
        applyStimulus(1, AL'(3), 40'h55_5555_5555, 1, AL'(4));
        runCycle();
        match = 0;
        for (int i = 0; i < 24; i++) begin
            runCycle();
            code    = oLdGnt ? 1 : (oFeGnt ? 2 : 0);
            expCode = (i < 8 || i >= 16) ? 1 : 2;
            if (code == expCode) match++;
        end
        checkVal("burst_pattern", 64'(match), 64'd24);
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        runCycle();

        // Owner stops after 3 beats, then a fresh tenure gets a full burst.
        applyStimulus(1, AL'(7), 40'h01_0203_0405, 0, '0);
        runCycle();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            runCycle();
            if (oLdGnt) n++;
        end
        checkVal("drop_beats", 64'(n), 64'd3);
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        runCycle();
        checkVal("drop_idle", 64'(oBusy), 64'd0);
        applyStimulus(1, AL'(8), 40'h0F_0F0F_0F0F, 0, '0);
        runCycle();
        runCycle();
        n = oLdGnt ? 1 : 0;
        applyStimulus(1, AL'(8), 40'h0F_0F0F_0F0F, 1, AL'(8));
        granted = 0;
        for (int i = 0; i < 20 && !granted; i++) begin
            runCycle();
            if (oLdGnt) n++;
            granted = oFeGnt;
        end
        if (!granted) failTimeout("restart_handover");
        checkVal("restart_burst_len", 64'(n), 64'(MB));
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        runCycle();

        // Reset in the middle of a fetch burst with a read in flight.
        applyStimulus(0, '0, '0, 1, AL'(5));
        runCycle();
        runCycle();
        runCycle();
        doReset();
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        checkVal("rst_no_stale_rvalid", 64'(oRvalid), 64'd0);
        runCycle();

        $display("[TB] random traffic phase");
        lastLdGnt = 0;
        lastFeGnt = 0;
        for (int seg = 0; seg < 6; seg++) begin
            case ($urandom_range(0, 2))
                0:       pLd = 20;
                1:       pLd = 60;
                default: pLd = 95;
            endcase
            case ($urandom_range(0, 2))
                0:       pFe = 20;
                1:       pFe = 60;
                default: pFe = 95;
            endcase
            for (int c = 0; c < 80; c++) begin
                if (!(ldReq && !lastLdGnt)) begin
                    rnd = {$urandom(), $urandom()};
                    rw  = rnd[DL-1:0];
                    ra  = AL'($urandom_range(0, 15));
                    applyStimulus(($urandom_range(0, 99) < 32'(pLd)), ra, rw, feReq, feAddr);
                end
                if (!(feReq && !lastFeGnt)) begin
                    ra = AL'($urandom_range(0, 15));
                    applyStimulus(ldReq, ldAddr, ldWdata, ($urandom_range(0, 99) < 32'(pFe)), ra);
                end
                if ($urandom_range(0, 199) == 0) doReset();
                runCycle();
                lastLdGnt = eLd;
                lastFeGnt = eFe;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
